// File: rtl/output_buffer_if.sv
// Stream/load bundle between the frame producer and the output_buffer serializer.
// last_out exists only when OUTPUT_BUFFER_LAST_EN is defined.
interface output_buffer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int BUFFER_SIZE = 256
);
  logic                              frame_load;
  logic [DATA_WIDTH*BUFFER_SIZE-1:0] frame_flat;
  logic                              buffer_free;
  logic                              flush;
  logic [DATA_WIDTH-1:0]             sample_out;
  logic                              valid_out;
  logic                              ready_in;
  logic                              frame_done;
`ifdef OUTPUT_BUFFER_LAST_EN
  logic                              last_out;
`endif

  modport master (
`ifdef OUTPUT_BUFFER_LAST_EN
    input  last_out,
`endif
    output frame_load, frame_flat, flush, ready_in,
    input  buffer_free, sample_out, valid_out, frame_done
  );

  modport slave (
`ifdef OUTPUT_BUFFER_LAST_EN
    output last_out,
`endif
    input  frame_load, frame_flat, flush, ready_in,
    output buffer_free, sample_out, valid_out, frame_done
  );
endinterface

// File: rtl/output_buffer.sv
// Frame-to-stream serializer: captures a packed frame in one cycle, emits samples 0..N-1
// over valid/ready. Optional last_out marker is enabled by OUTPUT_BUFFER_LAST_EN.
module output_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int BUFFER_SIZE = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  output_buffer_if.slave bus
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_SIZE - 1);

  typedef enum logic {
    EMPTY,
    STREAM
  } state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       read_ptr_q;
  logic                   valid_q;
  logic                   free_q;
  logic                   done_q;
  logic [DATA_WIDTH-1:0]  mem_q [BUFFER_SIZE];
  logic [DATA_WIDTH-1:0]  frame_samples [BUFFER_SIZE];
  logic                   load_accept;
  logic                   xfer;

  // Unpack the flat frame so that sample i sits at slot i.
  generate
    for (genvar gi = 0; gi < BUFFER_SIZE; gi++) begin : g_unpack
      assign frame_samples[gi] = bus.frame_flat[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH];
    end
  endgenerate

  assign load_accept = (state_q == EMPTY) && bus.frame_load && !bus.flush;
  assign xfer        = valid_q && bus.ready_in;

  // Storage carries no reset: stale contents are unreachable outside STREAM.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem_q[i] <= frame_samples[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      read_ptr_q <= '0;
      valid_q    <= 1'b0;
      free_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q    <= EMPTY;
        read_ptr_q <= '0;
        valid_q    <= 1'b0;
        free_q     <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            if (bus.frame_load) begin
              state_q    <= STREAM;
              read_ptr_q <= '0;
              valid_q    <= 1'b1;
              free_q     <= 1'b0;
            end
          end
          STREAM: begin
            if (xfer) begin
              if (read_ptr_q == LAST_PTR) begin
                state_q    <= EMPTY;
                read_ptr_q <= '0;
                valid_q    <= 1'b0;
                free_q     <= 1'b1;
                done_q     <= 1'b1;
              end else begin
                read_ptr_q <= read_ptr_q + 1'b1;
              end
            end
          end
          default: begin
            state_q    <= EMPTY;
            read_ptr_q <= '0;
            valid_q    <= 1'b0;
            free_q     <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.sample_out  = mem_q[read_ptr_q];
  assign bus.valid_out   = valid_q;
  assign bus.buffer_free = free_q;
  assign bus.frame_done  = done_q;

`ifdef OUTPUT_BUFFER_LAST_EN
  assign bus.last_out = valid_q && (read_ptr_q == LAST_PTR);
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer (DATA_WIDTH=16, BUFFER_SIZE=4) against a queue model.
// last_out is checked only when OUTPUT_BUFFER_LAST_EN is defined.
module tb_output_buffer;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int FW = DW * N;

  logic clk;
  logic reset_n;

  output_buffer_if #(.DATA_WIDTH(DW), .BUFFER_SIZE(N)) bus ();

  output_buffer #(.DATA_WIDTH(DW), .BUFFER_SIZE(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: samples still owed to downstream, oldest first.
  logic [DW-1:0] exp_q [$];
  logic          exp_done = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_done = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [FW-1:0] flat,
                            input logic fl, input logic rdy);
    exp_done = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (ld) begin
        for (int i = 0; i < N; i++) exp_q.push_back(flat[i*DW +: DW]);
      end
    end else if (rdy) begin
      $display("xfer sample=%04h remaining=%0d", exp_q[0], exp_q.size() - 1);
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) exp_done = 1'b1;
    end
  endtask

  task automatic compare_all();
    check_eq("valid_out",   {63'd0, bus.valid_out},   {63'd0, exp_q.size() != 0});
    check_eq("buffer_free", {63'd0, bus.buffer_free}, {63'd0, exp_q.size() == 0});
    check_eq("frame_done",  {63'd0, bus.frame_done},  {63'd0, exp_done});
    if (exp_q.size() != 0) check_eq("sample_out", {48'd0, bus.sample_out}, {48'd0, exp_q[0]});
`ifdef OUTPUT_BUFFER_LAST_EN
    check_eq("last_out", {63'd0, bus.last_out}, {63'd0, exp_q.size() == 1});
`endif
  endtask

  // Called at a falling edge; drives inputs, advances one clock, checks, returns at next falling edge.
  task automatic step(input logic ld, input logic [FW-1:0] flat,
                      input logic fl, input logic rdy);
    bus.frame_load = ld;
    bus.frame_flat = flat;
    bus.flush      = fl;
    bus.ready_in   = rdy;
    @(posedge clk);
    model_edge(ld, flat, fl, rdy);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  logic [FW-1:0] f1, f2, f3, rnd;

  initial begin
    f1 = 64'h0004_0003_0002_0001;
    f2 = 64'hAAAA_BBBB_CCCC_DDDD;
    f3 = 64'h0008_0007_0006_0005;
    bus.frame_load = 1'b0;
    bus.frame_flat = '0;
    bus.flush      = 1'b0;
    bus.ready_in   = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check_eq("rst_low_free",  {63'd0, bus.buffer_free}, 64'd1);
    check_eq("rst_low_valid", {63'd0, bus.valid_out},   64'd0);
    check_eq("rst_low_done",  {63'd0, bus.frame_done},  64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);

    // Basic stream with ready held high.
    step(1'b1, f1, 1'b0, 1'b1);
    check_eq("basic_first", {48'd0, bus.sample_out}, 64'h0001);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    check_eq("basic_last", {48'd0, bus.sample_out}, 64'h0004);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("basic_done", {63'd0, bus.frame_done}, 64'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure while sample 1 is shown.
    step(1'b1, f1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (3) begin
      step(1'b0, '0, 1'b0, 1'b0);
      check_eq("stall_hold", {48'd0, bus.sample_out}, 64'h0002);
    end
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);

    // Load while busy is ignored; reload right after frame_done.
    step(1'b1, f1, 1'b0, 1'b1);
    step(1'b1, f2, 1'b0, 1'b1);
    step(1'b1, f2, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("busy_done", {63'd0, bus.frame_done}, 64'd1);
    step(1'b1, f3, 1'b0, 1'b1);
    check_eq("reload_first", {48'd0, bus.sample_out}, 64'h0005);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);

    // Flush after two transfers.
    step(1'b1, f1, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, f2, 1'b1, 1'b1);
    check_eq("flush_valid", {63'd0, bus.valid_out}, 64'd0);
    step(1'b1, f3, 1'b0, 1'b1);
    check_eq("flush_reload", {48'd0, bus.sample_out}, 64'h0005);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset between edges after one transfer.
    step(1'b1, f1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_valid", {63'd0, bus.valid_out},   64'd0);
    check_eq("arst_free",  {63'd0, bus.buffer_free}, 64'd1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, f1, 1'b0, 1'b1);
    check_eq("arst_restart", {48'd0, bus.sample_out}, 64'h0001);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rnd = {$urandom, $urandom};
      step($urandom_range(0, 3) == 0, rnd, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_buffer.md
# output_buffer

Frame-to-stream serializer at the output end of the DSP accelerator datapath. Accepts one full processed frame as a packed parallel word in a single cycle, then emits its samples one at a time, index 0 first, over a valid/ready stream. It is the read-side counterpart of the input sample buffer, so frames leave the chiplet in the same packed layout and order in which they were collected.

## Interface
- DATA_WIDTH, 16, bits per sample
- BUFFER_SIZE, 256, samples per frame; must be ≥2
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_load  in  1  request to capture frame_flat
- frame_flat  in  DATA_WIDTH*BUFFER_SIZE  packed frame; sample i = bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- buffer_free  out  1  buffer empty, load will be accepted
- flush  in  1  synchronous abort of the current frame
- sample_out  out  DATA_WIDTH  current sample
- valid_out  out  1  sample_out is valid
- ready_in  in  1  downstream accepts sample
- frame_done  out  1  one-cycle pulse after the last sample is transferred
- last_out  out  1  present only with OUTPUT_BUFFER_LAST_EN; see Configuration

## Operation
- Internal storage: BUFFER_SIZE × DATA_WIDTH array; read_ptr of $clog2(BUFFER_SIZE) bits.
- FSM has two states:
  - EMPTY: buffer_free=1, valid_out=0.
  - STREAM: buffer_free=0, valid_out=1.
- EMPTY→STREAM on frame_load. All BUFFER_SIZE samples are copied into the array in that cycle and read_ptr is set to 0.
- frame_load in STREAM is ignored. Frame_flat is not sampled and there is no error flag.
- Transfer happens on a cycle with valid_out && ready_in; read_ptr then increments.
- sample_out = array[read_ptr]. It is held stable while valid_out && !ready_in.
- Transfer with read_ptr == BUFFER_SIZE-1 (final sample):
  - Go to EMPTY.
  - Reset read_ptr to 0.
  - Register frame_done=1 for the next cycle only.
- flush has priority over every other event:
  - From any state, go to EMPTY and set read_ptr to 0.
  - No frame_done pulse.
  - If flush and frame_load occur in the same cycle, the load is ignored.
- Array contents are not cleared by reset or flush.
- sample_out is a don't-care outside STREAM. The bench must check it only when valid_out=1.

## Timing
- Reset values: state EMPTY, buffer_free=1, valid_out=0, frame_done=0, read_ptr=0, last_out=0.
- Load to first sample: frame_load sampled at edge N gives valid_out=1 and sample_out=sample 0 after edge N.
- Throughput: with ready_in held high, one sample per cycle. A frame takes BUFFER_SIZE cycles from first valid to last transfer.
- After the final transfer at edge M:
  - buffer_free=1 and frame_done=1 after edge M.
  - A new frame_load sampled at edge M+1 is accepted.
  - The minimum frame-to-frame gap is therefore one idle cycle.
- ready_in may toggle arbitrarily. Stalls are unbounded and lose no data.
- reset_n low mid-stream: outputs go immediately (asynchronously) to reset values. The partially sent frame is discarded.

## Configuration
- OUTPUT_BUFFER_LAST_EN defined:
  - Adds output port last_out (1 bit).
  - last_out = valid_out && (read_ptr == BUFFER_SIZE-1), so it is asserted alongside the final sample and held during stalls.
- Not defined:
  - The port does not exist.
  - All other behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=16 and BUFFER_SIZE=4.
- Reset then idle: buffer_free=1, valid_out=0, frame_done=0. The check is made while reset_n is low and again after release.
- Basic stream: load frame_flat=64'h0004_0003_0002_0001 with ready_in=1. Required response:
  - sample_out is 0x0001, 0x0002, 0x0003, 0x0004 on 4 consecutive cycles.
  - frame_done pulses once on the following cycle.
  - last_out is high with 0x0004 only (macro on).
- Backpressure: same frame with ready_in=0 for 3 cycles while sample 1 is shown. Required response:
  - sample_out holds 0x0002 and valid_out stays 1 throughout the stall.
  - The sequence then completes with no loss or duplication.
- Load while busy: a second frame_load of 64'hAAAA_BBBB_CCCC_DDDD during STREAM is ignored. The first frame completes unchanged, then a new load is accepted one cycle after frame_done.
- Flush mid-frame: flush after 2 transfers. Required response:
  - Next cycle: valid_out=0 and buffer_free=1, with no frame_done.
  - Reloading 64'h0008_0007_0006_0005 streams 0x0005 first.
- Async reset mid-stream: drop reset_n between clock edges after 1 transfer. valid_out=0 immediately, and the next load restarts at sample 0.
